// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall arbitration, exception flush/redirect with one refill
// cycle, saturating stall-cycle counter and stall-hang watchdog.
module pipe_ctrl #(
    parameter logic [31:0] INT_VECTOR    = 32'h0000_0020,
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040,
    parameter int          STALL_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles_o,
    output logic        timeout_o
);

    localparam int              HW        = $clog2(STALL_TIMEOUT + 1);
    localparam logic [HW-1:0]   HANG_LAST = HW'(STALL_TIMEOUT - 1);
    localparam logic [31:0]     EXC_INT   = 32'h0000_0001;
    localparam logic [31:0]     EXC_ERET  = 32'h0000_000e;

    typedef enum logic {RUN, REFILL} state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hang_cnt;

    function automatic logic [5:0] arb_stall(input logic mem, input logic ex,
                                             input logic id, input logic ifs);
        if (mem)             return 6'b011111;
        else if (ex)         return 6'b001111;
        else if (id || ifs)  return 6'b000111;
        else                 return 6'b000000;
    endfunction

    function automatic logic [31:0] redirect(input logic [31:0] code, input logic [31:0] epc);
        if (code == EXC_INT)       return INT_VECTOR;
        else if (code == EXC_ERET) return epc;
        else                       return EXC_VECTOR;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (excepttype_i != 32'd0) state_nxt = REFILL;
            REFILL:  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Exceptions are only taken in RUN; the refill cycle still honours stall requests.
    always_comb begin
        stall  = 6'b000000;
        flush  = 1'b0;
        new_pc = 32'd0;
        if (rst) begin
            stall = 6'b000000;
        end else if (state == RUN && excepttype_i != 32'd0) begin
            flush  = 1'b1;
            new_pc = redirect(excepttype_i, cp0_epc_i);
        end else begin
            stall = arb_stall(stallreq_from_mem, stallreq_from_ex,
                              stallreq_from_id, stallreq_from_if);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_o <= 32'd0;
            hang_cnt       <= '0;
            timeout_o      <= 1'b0;
        end else begin
            if (stall != 6'b000000 && stall_cycles_o != 32'hFFFF_FFFF)
                stall_cycles_o <= stall_cycles_o + 32'd1;
            timeout_o <= 1'b0;
            if (flush || stall == 6'b000000) begin
                hang_cnt <= '0;
            end else if (hang_cnt == HANG_LAST) begin
                hang_cnt  <= '0;
                timeout_o <= 1'b1;
            end else begin
                hang_cnt <= hang_cnt + HW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Table-driven bench for pipe_ctrl with a scoreboard queue; a second instance
// with a short watchdog timeout exercises the timeout pulse.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_if, s_id, s_ex, s_mem;
    logic [31:0] exc, epc;
    logic [5:0]  stall_a, stall_b;
    logic        flush_a, flush_b, to_a, to_b;
    logic [31:0] npc_a, npc_b, cyc_a, cyc_b;

    always #5 clk = ~clk;

    pipe_ctrl dut_a (
        .clk(clk), .rst(rst),
        .stallreq_from_if(s_if), .stallreq_from_id(s_id),
        .stallreq_from_ex(s_ex), .stallreq_from_mem(s_mem),
        .excepttype_i(exc), .cp0_epc_i(epc),
        .stall(stall_a), .flush(flush_a), .new_pc(npc_a),
        .stall_cycles_o(cyc_a), .timeout_o(to_a)
    );

    pipe_ctrl #(.STALL_TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst),
        .stallreq_from_if(s_if), .stallreq_from_id(s_id),
        .stallreq_from_ex(s_ex), .stallreq_from_mem(s_mem),
        .excepttype_i(exc), .cp0_epc_i(epc),
        .stall(stall_b), .flush(flush_b), .new_pc(npc_b),
        .stall_cycles_o(cyc_b), .timeout_o(to_b)
    );

    typedef struct {
        logic        mem, ex, id, ifs;
        logic [31:0] exc, epc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] cyc;
        logic        to_a, to_b;
    } exp_t;

    localparam int NV = 36;
    vec_t vt[NV];
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // Counter/watchdog reference model
    logic [31:0] m_cyc;
    int          m_hang_a, m_hang_b;
    logic        m_to_a, m_to_b;

    function automatic void set_v(int i, logic mem, logic ex, logic id, logic ifs,
                                  logic [31:0] x, logic [31:0] p,
                                  logic [5:0] es, logic ef, logic [31:0] ep);
        vt[i].mem = mem; vt[i].ex = ex; vt[i].id = id; vt[i].ifs = ifs;
        vt[i].exc = x; vt[i].epc = p;
        vt[i].e_stall = es; vt[i].e_flush = ef; vt[i].e_pc = ep;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_hang_a = 0; m_hang_b = 0; m_to_a = 0; m_to_b = 0;
    endtask

    task automatic model_edge(input logic [5:0] es, input logic ef);
        if (es != 0 && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
        if (ef || es == 0) begin
            m_hang_a = 0; m_to_a = 0; m_hang_b = 0; m_to_b = 0;
        end else begin
            m_hang_a = m_hang_a + 1; m_to_a = (m_hang_a == 1023);
            if (m_to_a) m_hang_a = 0;
            m_hang_b = m_hang_b + 1; m_to_b = (m_hang_b == 4);
            if (m_to_b) m_hang_b = 0;
        end
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic push_exp(input logic [5:0] s, input logic f, input logic [31:0] p);
        exp_t e;
        e.stall = s; e.flush = f; e.pc = p;
        e.cyc = m_cyc; e.to_a = m_to_a; e.to_b = m_to_b;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s scoreboard: got empty want entry", tag);
            return;
        end
        e = sb.pop_front();
        cmp({tag, " stall"},  {26'd0, stall_a}, {26'd0, e.stall});
        cmp({tag, " flush"},  {31'd0, flush_a}, {31'd0, e.flush});
        cmp({tag, " new_pc"}, npc_a, e.pc);
        cmp({tag, " cycles"}, cyc_a, e.cyc);
        cmp({tag, " to_a"},   {31'd0, to_a},    {31'd0, e.to_a});
        cmp({tag, " stall_b"}, {26'd0, stall_b}, {26'd0, e.stall});
        cmp({tag, " to_b"},   {31'd0, to_b},    {31'd0, e.to_b});
    endtask

    task automatic apply(input int i);
        @(negedge clk);
        s_mem = vt[i].mem; s_ex = vt[i].ex; s_id = vt[i].id; s_if = vt[i].ifs;
        exc = vt[i].exc; epc = vt[i].epc;
        push_exp(vt[i].e_stall, vt[i].e_flush, vt[i].e_pc);
        #2;
        check_out($sformatf("v%0d", i));
        @(posedge clk);
        model_edge(vt[i].e_stall, vt[i].e_flush);
    endtask

    task automatic idle_inputs();
        s_mem = 0; s_ex = 0; s_id = 0; s_if = 0; exc = 0; epc = 0;
    endtask

    initial begin
        // Reset + mem/ex priority
        set_v(0,  1,1,0,0, 32'h0, 32'h0, 6'b011111, 0, 32'h0);
        set_v(1,  0,1,0,0, 32'h0, 32'h0, 6'b001111, 0, 32'h0);
        set_v(2,  0,0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);
        // Interrupt, then exception held through refill
        set_v(3,  0,0,0,0, 32'h1, 32'h0, 6'b000000, 1, 32'h20);
        set_v(4,  0,0,0,0, 32'h8, 32'h0, 6'b000000, 0, 32'h0);
        set_v(5,  0,0,0,0, 32'h8, 32'h0, 6'b000000, 1, 32'h40);
        set_v(6,  0,0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);
        // ERET overrides a MEM stall; stall honoured during refill
        set_v(7,  1,0,0,0, 32'he, 32'h1234, 6'b000000, 1, 32'h1234);
        set_v(8,  1,0,0,0, 32'h0, 32'h1234, 6'b011111, 0, 32'h0);
        set_v(9,  0,0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);
        // ID stall for 5 cycles
        for (int k = 10; k < 15; k++)
            set_v(k, 0,0,1,0, 32'h0, 32'h0, 6'b000111, 0, 32'h0);
        set_v(15, 0,0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);
        // Remaining priority combinations
        set_v(16, 0,0,0,1, 32'h0, 32'h0, 6'b000111, 0, 32'h0);
        set_v(17, 0,0,1,1, 32'h0, 32'h0, 6'b000111, 0, 32'h0);
        set_v(18, 0,1,1,1, 32'h0, 32'h0, 6'b001111, 0, 32'h0);
        set_v(19, 1,0,0,1, 32'h0, 32'h0, 6'b011111, 0, 32'h0);
        set_v(20, 0,0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);
        // EX held 9 cycles: short-timeout instance pulses twice
        for (int k = 21; k < 30; k++)
            set_v(k, 0,1,0,0, 32'h0, 32'h0, 6'b001111, 0, 32'h0);
        set_v(30, 0,0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);
        // Flush that enters REFILL, then reset mid-REFILL (hand sequence)
        set_v(31, 0,0,0,0, 32'h3, 32'h0, 6'b000000, 1, 32'h40);
        // After reset: state must be RUN again
        set_v(32, 0,0,0,0, 32'h1, 32'h0, 6'b000000, 1, 32'h20);
        set_v(33, 0,0,0,0, 32'h3, 32'h0, 6'b000000, 0, 32'h0);
        set_v(34, 0,0,0,0, 32'h3, 32'h0, 6'b000000, 1, 32'h40);
        set_v(35, 0,0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);

        rst = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        push_exp(6'b0, 1'b0, 32'h0);
        check_out("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i <= 31; i++) apply(i);

        // Reset asserted in REFILL while MEM requests a stall
        @(negedge clk);
        s_mem = 1'b1;
        #1;
        push_exp(6'b011111, 1'b0, 32'h0);
        check_out("refill_pre_rst");
        rst = 1'b1;
        model_reset();
        #1;
        push_exp(6'b0, 1'b0, 32'h0);
        check_out("mid_refill_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        for (int i = 32; i < NV; i++) apply(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timed out");
    end

endmodule
